// File: rtl/softmax_stream_fx.sv
// Streaming fixed-point softmax: buffers N logits, subtracts the max, looks up exp in a ROM,
// accumulates the sum and emits each probability through a serial restoring divider.
module softmax_stream_fx #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int NMAX   = 32,
  parameter int OUT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(NMAX+1)-1:0]  n,
  input  logic [DATA_W-1:0]          datain,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [OUT_W-1:0]           dataout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
  output logic                       busy,
  output logic                       error
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_LOAD | accepting N logits, tracking the max
  // S_EXP  | one exp lookup per element, summing
  // S_DIV  | OUT_W+1 cycle division of ebuf[idx] by the sum
  // S_EMIT | holding a probability until the sink takes it

  localparam int NW    = $clog2(NMAX + 1);
  localparam int AW    = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int SUM_W = 16 + NW;
  localparam int CW    = $clog2(OUT_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXP, S_DIV, S_EMIT} state_t;
  state_t state, state_nx;

  // round(2^15 * exp(-idx/32)), evaluated at elaboration in Q60 fixed point
  function automatic logic [15:0] exp_entry(input int idx);
    logic [127:0] r, t, v;
    r = 128'd1 << 60;
    t = r;
    for (int k = 1; k <= 12; k++) begin
      t = t / 128'(32 * k);
      if (k % 2 == 1) r = r - t;
      else            r = r + t;
    end
    v = 128'd1 << 60;
    for (int j = 0; j < idx; j++) v = (v * r + (128'd1 << 59)) >> 60;
    v = (v + (128'd1 << 44)) >> 45;
    return v[15:0];
  endfunction

  logic [15:0] rom [256];
  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [15:0] VAL = exp_entry(g);
    assign rom[g] = VAL;
  end

  logic [NW-1:0]            len, idx;
  logic signed [DATA_W-1:0] max_v;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W:0]           rem, rem_cur, rem_nx;
  logic [OUT_W-1:0]         quo;
  logic [OUT_W:0]           quo_nx;
  logic [CW-1:0]            div_cnt;
  logic [DATA_W-1:0]        buf_mem [NMAX];
  logic [15:0]              ebuf [NMAX];

  logic              start_ok, in_beat, idx_last, ge;
  logic [DATA_W-1:0] cur;
  logic [DATA_W:0]   diff, shifted;
  logic [15:0]       e_val;

  assign start_ok = start && (n != '0) && (n <= NW'(NMAX));
  assign in_beat  = din_valid && (state == S_LOAD);
  assign idx_last = (idx == len - NW'(1));

  assign cur     = buf_mem[idx[AW-1:0]];
  assign diff    = {max_v[DATA_W-1], max_v} - {cur[DATA_W-1], cur};
  assign shifted = diff >> (FRAC_W - 5);
  assign e_val   = (shifted <= (DATA_W+1)'(255)) ? rom[shifted[7:0]] : 16'd0;

  // first division step of an element starts from the raw exp value
  assign rem_cur = (div_cnt == CW'(OUT_W)) ? (SUM_W+1)'(ebuf[idx[AW-1:0]]) : rem;
  assign ge      = rem_cur >= {1'b0, sum};
  assign rem_nx  = (ge ? rem_cur - {1'b0, sum} : rem_cur) << 1;
  assign quo_nx  = {quo, ge};

  assign din_ready  = (state == S_LOAD);
  assign dout_valid = (state == S_EMIT);
  assign dout_last  = (state == S_EMIT) && idx_last;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_ok) state_nx = S_LOAD;
      S_LOAD: if (in_beat && idx_last) state_nx = S_EXP;
      S_EXP:  if (idx_last) state_nx = S_DIV;
      S_DIV:  if (div_cnt == '0) state_nx = S_EMIT;
      S_EMIT: if (dout_ready) state_nx = idx_last ? S_IDLE : S_DIV;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      len     <= '0;
      idx     <= '0;
      max_v   <= '0;
      sum     <= '0;
      rem     <= '0;
      quo     <= '0;
      div_cnt <= '0;
      dataout <= '0;
      error   <= 1'b0;
    end else begin
      error <= (state == S_IDLE) && start && !start_ok;
      case (state)
        S_IDLE: if (start_ok) begin
          len   <= n;
          idx   <= '0;
          max_v <= {1'b1, {(DATA_W-1){1'b0}}};
          sum   <= '0;
        end
        S_LOAD: if (in_beat) begin
          if ($signed(datain) > max_v) max_v <= $signed(datain);
          idx <= idx_last ? '0 : idx + NW'(1);
        end
        S_EXP: begin
          sum <= sum + SUM_W'(e_val);
          idx <= idx_last ? '0 : idx + NW'(1);
          if (idx_last) div_cnt <= CW'(OUT_W);
        end
        S_DIV: begin
          rem     <= rem_nx;
          quo     <= quo_nx[OUT_W-1:0];
          div_cnt <= div_cnt - CW'(1);
          if (div_cnt == '0) dataout <= quo_nx[OUT_W] ? '1 : quo_nx[OUT_W-1:0];
        end
        S_EMIT: if (dout_ready && !idx_last) begin
          idx     <= idx + NW'(1);
          div_cnt <= CW'(OUT_W);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (in_beat)         buf_mem[idx[AW-1:0]] <= datain;
    if (state == S_EXP)  ebuf[idx[AW-1:0]]    <= e_val;
  end

endmodule
